// File: rtl/spi_controller.sv
// SPI mode-0 master: byte-stream interface in, SCK/CSN/MOSI out, MISO sampled
// on SCK rising edges. One frame is a run of bytes closed by tx_last.
module spi_controller #(
  parameter int BYTE_W   = 8,
  parameter int CLK_HALF = 6
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              SCK_PAD,
  output logic              CSN_PAD,
  output logic              MOSI_PAD,
  input  logic              MISO_PAD
);

  localparam int CNT_W  = 8;
  localparam int HALF_W = $clog2(2 * BYTE_W);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(CLK_HALF - 1);
  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(2 * BYTE_W - 1);
  localparam logic [HALF_W-1:0] HALF_LFALL = HALF_W'(2 * BYTE_W - 2);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, DONE, GAP, HOLD, DESEL
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;      // sys_clk cycles within the current half-period
  logic [HALF_W-1:0] half;     // SCK half-period index within the byte
  logic              lead;     // extra low half before the first rise of a GAP byte
  logic              last_q;   // tx_last latched with the byte in flight
  logic [BYTE_W-1:0] tx_sr;
  logic [BYTE_W-1:0] rx_sr;
  logic              cnt_end;
  logic              accept;

  assign cnt_end = (cnt == CNT_MAX);
  assign accept  = tx_valid && tx_ready;

  // Frame sequencer: every pad and handshake output is registered here.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      half     <= '0;
      lead     <= 1'b0;
      last_q   <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      SCK_PAD  <= 1'b0;
      CSN_PAD  <= 1'b1;
      MOSI_PAD <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_sr    <= tx_data;
            last_q   <= tx_last;
            MOSI_PAD <= tx_data[BYTE_W-1];
            CSN_PAD  <= 1'b0;
            cnt      <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_end) begin
            cnt     <= '0;
            half    <= '0;
            lead    <= 1'b0;
            SCK_PAD <= 1'b1;
            rx_sr   <= {rx_sr[BYTE_W-2:0], MISO_PAD};
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (!cnt_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (lead) begin
              // GAP bytes change MOSI on entry, so the first rise waits a
              // half-period to give the peripheral a settled bit.
              lead    <= 1'b0;
              half    <= '0;
              SCK_PAD <= 1'b1;
              rx_sr   <= {rx_sr[BYTE_W-2:0], MISO_PAD};
            end else if (half == HALF_LAST) begin
              rx_data  <= rx_sr;
              rx_valid <= 1'b1;
              state    <= DONE;
            end else begin
              half <= half + 1'b1;
              if (!half[0]) begin
                SCK_PAD <= 1'b0;
                if (half != HALF_LFALL) begin
                  tx_sr    <= {tx_sr[BYTE_W-2:0], 1'b0};
                  MOSI_PAD <= tx_sr[BYTE_W-2];
                end
              end else begin
                SCK_PAD <= 1'b1;
                rx_sr   <= {rx_sr[BYTE_W-2:0], MISO_PAD};
              end
            end
          end
        end
        DONE: begin
          cnt      <= '0;
          tx_ready <= !last_q;
          state    <= last_q ? HOLD : GAP;
        end
        GAP: begin
          if (accept) begin
            tx_sr    <= tx_data;
            last_q   <= tx_last;
            MOSI_PAD <= tx_data[BYTE_W-1];
            lead     <= 1'b1;
            cnt      <= '0;
            tx_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        HOLD: begin
          if (cnt_end) begin
            cnt      <= '0;
            CSN_PAD  <= 1'b1;
            MOSI_PAD <= 1'b0;
            state    <= DESEL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DESEL: begin
          if (cnt_end) begin
            cnt      <= '0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a mode-0 peripheral model with response queue,
// scoreboarded rx/MOSI bytes, table-driven frames and timing sequences.
module tb_spi_controller;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  // DUT A: CLK_HALF = 6
  logic [7:0] tx_data_a;
  logic       tx_last_a, tx_valid_a, tx_ready_a;
  logic [7:0] rx_data_a;
  logic       rx_valid_a, busy_a, sck_a, csn_a, mosi_a, miso_a;
  // DUT B: CLK_HALF = 1, MISO looped back from MOSI
  logic [7:0] tx_data_b;
  logic       tx_last_b, tx_valid_b, tx_ready_b;
  logic [7:0] rx_data_b;
  logic       rx_valid_b, busy_b, sck_b, csn_b, mosi_b;

  always #5 sys_clk = ~sys_clk;

  spi_controller #(.BYTE_W(8), .CLK_HALF(6)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(tx_data_a), .tx_last(tx_last_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .busy(busy_a), .SCK_PAD(sck_a), .CSN_PAD(csn_a),
    .MOSI_PAD(mosi_a), .MISO_PAD(miso_a));

  spi_controller #(.BYTE_W(8), .CLK_HALF(1)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(tx_data_b), .tx_last(tx_last_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .busy(busy_b), .SCK_PAD(sck_b), .CSN_PAD(csn_b),
    .MOSI_PAD(mosi_b), .MISO_PAD(mosi_b));

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues
  logic [7:0] resp_q[$];      // bytes the peripheral will return
  logic [7:0] exp_rx_q[$];    // bytes expected on rx_data at rx_valid
  logic [7:0] exp_mosi_q[$];  // bytes expected on MOSI at SCK rises

  task automatic push_exp(input logic [7:0] tx, input logic [7:0] resp);
    resp_q.push_back(resp);
    exp_rx_q.push_back(resp);
    exp_mosi_q.push_back(tx);
  endtask

  // Mode-0 peripheral model for DUT A
  logic       p_sck_q = 1'b0;
  logic       p_csn_q = 1'b1;
  logic [7:0] p_tx = 8'h00;
  logic [7:0] p_rx = 8'h00;
  int         p_bits = 0;
  int         rise_cnt = 0;
  int         csn_rise_cnt = 0;
  int         mosi_viol = 0;

  always @(negedge sys_clk) begin
    if (sck_a === 1'b1 && p_sck_q === 1'b0 && csn_a === 1'b0) begin
      if (p_bits == 0 && resp_q.size() > 0) void'(resp_q.pop_front());
      p_rx = {p_rx[6:0], mosi_a};
      p_bits++;
      rise_cnt++;
      if (p_bits == 8) begin
        if (exp_mosi_q.size() == 0) check("mosi_unexpected_byte", {24'd0, p_rx}, 32'hFFFF_FFFF);
        else check("mosi_byte", {24'd0, p_rx}, {24'd0, exp_mosi_q.pop_front()});
      end
    end
    if (sck_a === 1'b0 && p_sck_q === 1'b1 && csn_a === 1'b0) begin
      if (p_bits == 8) p_bits = 0;
      else begin
        p_tx = {p_tx[6:0], 1'b0};
        miso_a = p_tx[7];
      end
    end
    if (csn_a === 1'b1) begin
      p_bits = 0;
      miso_a = 1'b0;
    end else if (csn_a === 1'b0 && p_bits == 0 && sck_a === 1'b0 && resp_q.size() > 0) begin
      p_tx = resp_q[0];
      miso_a = p_tx[7];
    end
    if (csn_a === 1'b1 && p_csn_q === 1'b0) csn_rise_cnt++;
    if (csn_a === 1'b1 && mosi_a !== 1'b0) mosi_viol++;
    p_sck_q = sck_a;
    p_csn_q = csn_a;
  end

  // rx scoreboard for DUT A
  always @(negedge sys_clk) begin
    if (rx_valid_a === 1'b1) begin
      if (exp_rx_q.size() == 0) check("rx_unexpected", {24'd0, rx_data_a}, 32'hFFFF_FFFF);
      else check("rx_byte", {24'd0, rx_data_a}, {24'd0, exp_rx_q.pop_front()});
    end
  end

  task automatic send_a(input logic [7:0] d, input logic last);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge sys_clk);
      if (tx_ready_a) break;
    end
    if (k == 2000) check("send_ready_timeout", 1, 0);
    tx_data_a  = d;
    tx_last_a  = last;
    tx_valid_a = 1'b1;
    @(posedge sys_clk);
    #1 tx_valid_a = 1'b0;
  endtask

  task automatic wait_idle_a();
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge sys_clk);
      if (!busy_a) break;
    end
    if (k == 2000) check("idle_timeout", 1, 0);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       last;
    logic [7:0] resp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_csn, t_sck, t_rxv, t_csnh, t_idle, nbytes, base_r, base_c, run, k;
    int errs, t_rx;
    logic [7:0] got;

    vecs[0] = '{8'h05, 1'b0, 8'hAA};
    vecs[1] = '{8'h07, 1'b1, 8'h43};
    vecs[2] = '{8'hFF, 1'b1, 8'h00};
    vecs[3] = '{8'h00, 1'b1, 8'hFF};
    vecs[4] = '{8'h81, 1'b0, 8'h7E};
    vecs[5] = '{8'h3C, 1'b0, 8'h99};
    vecs[6] = '{8'hC3, 1'b1, 8'h24};

    sys_rst = 1'b1;
    tx_data_a = 8'h00; tx_last_a = 1'b0; tx_valid_a = 1'b0;
    tx_data_b = 8'h00; tx_last_b = 1'b0; tx_valid_b = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_csn", csn_a, 1);
    check("rst_sck", sck_a, 0);
    check("rst_mosi", mosi_a, 0);
    check("rst_rx_data", rx_data_a, 0);
    check("rst_rx_valid", rx_valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_tx_ready", tx_ready_a, 1);

    // Single byte 0xA5 / 0x3C latency profile
    push_exp(8'hA5, 8'h3C);
    tx_data_a = 8'hA5; tx_last_a = 1'b1; tx_valid_a = 1'b1;
    @(posedge sys_clk);
    #1 tx_valid_a = 1'b0;
    t_csn = -1; t_sck = -1; t_rxv = -1; t_csnh = -1; t_idle = -1;
    for (int c = 1; c <= 130; c++) begin
      @(negedge sys_clk);
      if (t_csn < 0 && !csn_a) t_csn = c;
      if (t_sck < 0 && sck_a) t_sck = c;
      if (t_rxv < 0 && rx_valid_a) t_rxv = c;
      if (t_csn >= 0 && t_csnh < 0 && csn_a) t_csnh = c;
      if (t_csn >= 0 && t_idle < 0 && !busy_a) t_idle = c;
    end
    check("lat_csn_fall", t_csn, 1);
    check("lat_first_sck", t_sck, 7);
    check("lat_rx_valid", t_rxv, 103);
    check("lat_csn_rise", t_csnh, 110);
    check("lat_busy_low", t_idle, 116);
    check("rx_data_hold", rx_data_a, 8'h3C);

    // Table-driven frames
    nbytes = 0; base_r = rise_cnt; base_c = csn_rise_cnt;
    for (int i = 0; i < 7; i++) begin
      push_exp(vecs[i].tx, vecs[i].resp);
      send_a(vecs[i].tx, vecs[i].last);
      nbytes++;
      if (vecs[i].last) begin
        wait_idle_a();
        check("frame_sck_rises", rise_cnt - base_r, 8 * nbytes);
        check("frame_csn_rises", csn_rise_cnt - base_c, 1);
        nbytes = 0; base_r = rise_cnt; base_c = csn_rise_cnt;
      end
    end

    // Reset after the 4th SCK rise aborts the frame
    resp_q.push_back(8'h55);
    base_r = rise_cnt;
    send_a(8'hFF, 1'b1);
    for (k = 0; k < 500; k++) begin
      @(negedge sys_clk); #1;
      if (rise_cnt >= base_r + 4) break;
    end
    if (k == 500) check("abort_rise_timeout", 1, 0);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    check("abort_csn", csn_a, 1);
    check("abort_sck", sck_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_tx_ready", tx_ready_a, 1);
    base_r = rise_cnt;
    repeat (120) @(negedge sys_clk);
    check("abort_no_more_rises", rise_cnt - base_r, 0);
    push_exp(8'h81, 8'h18);
    send_a(8'h81, 1'b1);
    wait_idle_a();
    check("after_abort_rises", rise_cnt - base_r, 8);

    // tx_valid held during a busy frame: accepted once, only from IDLE
    push_exp(8'h96, 8'h69);
    push_exp(8'h11, 8'hE7);
    base_r = rise_cnt; base_c = csn_rise_cnt;
    send_a(8'h96, 1'b1);
    tx_data_a = 8'h11; tx_last_a = 1'b1; tx_valid_a = 1'b1;
    for (k = 0; k < 500; k++) begin
      @(negedge sys_clk);
      if (tx_ready_a) break;
    end
    if (k == 500) check("held_accept_timeout", 1, 0);
    check("held_accept_in_idle", busy_a, 0);
    check("held_accept_after_desel", csn_rise_cnt - base_c, 1);
    @(posedge sys_clk);
    #1 tx_valid_a = 1'b0;
    wait_idle_a();
    check("held_total_rises", rise_cnt - base_r, 16);

    // Back-to-back frames with tx_valid held high
    push_exp(8'h12, 8'h21);
    push_exp(8'h34, 8'h43);
    send_a(8'h12, 1'b1);
    tx_data_a = 8'h34; tx_last_a = 1'b1; tx_valid_a = 1'b1;
    for (k = 0; k < 500; k++) begin
      @(negedge sys_clk);
      if (csn_a) break;
    end
    if (k == 500) check("b2b_csn_timeout", 1, 0);
    run = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge sys_clk);
      if (!csn_a) break;
      run++;
      if (tx_valid_a && tx_ready_a) begin
        @(posedge sys_clk);
        #1 tx_valid_a = 1'b0;
      end
    end
    compared++;
    if (run < 7) begin
      mismatched++;
      $display("FAIL b2b_csn_high: got %0d cycles, expected >= 7", run);
    end
    wait_idle_a();

    // CLK_HALF = 1 with loopback
    @(negedge sys_clk);
    tx_data_b = 8'h5A; tx_last_b = 1'b1; tx_valid_b = 1'b1;
    @(posedge sys_clk);
    #1 tx_valid_b = 1'b0;
    errs = 0; t_rx = -1; got = 8'h00;
    for (int c = 1; c <= 30; c++) begin
      @(negedge sys_clk);
      if (c >= 2 && c <= 17 && sck_b !== ((c % 2) == 0)) errs++;
      if ((c == 1 || c == 18) && sck_b !== 1'b0) errs++;
      if (t_rx < 0 && rx_valid_b) begin
        t_rx = c;
        got = rx_data_b;
      end
    end
    check("fast_sck_pattern_errs", errs, 0);
    check("fast_rx_valid_cycle", t_rx, 18);
    check("fast_rx_data", got, 8'h5A);

    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("mosi_queue_drained", exp_mosi_q.size(), 0);
    check("resp_queue_drained", resp_q.size(), 0);
    check("mosi_low_while_deselected", mosi_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter BYTE_W, default 8, giving bits per SPI byte.
REQ-002 SHALL have parameter CLK_HALF, default 6, giving sys_clk cycles per SCK half-period (legal range 1..255; 6 gives 2 MHz SCK from 24 MHz).
REQ-003 SHALL have port sys_clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port sys_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port tx_data  input  BYTE_W  byte to transmit, MSB first.
REQ-006 SHALL have port tx_last  input  1  byte ends the frame; sampled with tx_data.
REQ-007 SHALL have port tx_valid  input  1  tx_data/tx_last valid.
REQ-008 SHALL have port tx_ready  output  1  controller accepts a byte this cycle.
REQ-009 SHALL have port rx_data  output  BYTE_W  byte received on MISO_PAD.
REQ-010 SHALL have port rx_valid  output  1  one-cycle strobe, rx_data new.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have ports SCK_PAD, CSN_PAD, MOSI_PAD (outputs, 1 bit) and MISO_PAD (input, 1 bit), driving a peripheral in SPI mode 0.

Function
REQ-013 SHALL transfer a byte only on the cycle where tx_valid and tx_ready are both 1.
REQ-014 SHALL implement the states IDLE, SETUP, SHIFT, DONE, GAP, HOLD and DESEL.
REQ-015 IDLE: tx_ready=1, CSN_PAD=1, SCK_PAD=0; on accept, load the shift register, go to SETUP, drive CSN_PAD=0 and MOSI_PAD=tx_data MSB on the next cycle.
REQ-016 SETUP SHALL last CLK_HALF cycles with SCK_PAD=0, then go to SHIFT.
REQ-017 SHIFT SHALL toggle SCK_PAD every CLK_HALF cycles, producing BYTE_W rising and BYTE_W falling edges (2*BYTE_W*CLK_HALF cycles).
REQ-018 On each SCK rising edge, the controller SHALL sample MISO_PAD into the LSB of the receive shift register.
REQ-019 On each SCK falling edge except the last, the controller SHALL shift and present the next MOSI bit.
REQ-020 After the final falling edge, the controller SHALL enter DONE for 1 cycle with rx_data updated and rx_valid=1.
REQ-021 DONE SHALL go to HOLD if the latched tx_last=1, else to GAP.
REQ-022 GAP: CSN_PAD=0, SCK_PAD=0, tx_ready=1; remains indefinitely until accept, then loads the byte and goes directly to SHIFT (no SETUP), MOSI updated on the next cycle.
REQ-023 HOLD SHALL last CLK_HALF cycles with CSN_PAD=0, then drive CSN_PAD=1 and enter DESEL.
REQ-024 DESEL SHALL last CLK_HALF cycles with CSN_PAD=1 and tx_ready=0, then enter IDLE.
REQ-025 tx_ready SHALL be 0 in SETUP, SHIFT, DONE, HOLD and DESEL; tx_valid in those states is ignored and not queued.
REQ-026 rx_valid has no backpressure; a consumer missing the strobe loses the byte, and rx_data holds its value until the next DONE.
REQ-027 Single-byte latency: accept at cycle 0, CSN_PAD falls at cycle 1, first SCK rise at cycle 1+CLK_HALF, rx_valid at cycle 1+CLK_HALF+2*BYTE_W*CLK_HALF.
REQ-028 With CLK_HALF=1, SCK_PAD SHALL toggle every cycle with no skipped or doubled edges.
REQ-029 MOSI_PAD SHALL be 0 whenever CSN_PAD=1.

Reset
REQ-030 While sys_rst=1 at a rising edge, the controller SHALL enter IDLE and set CSN_PAD=1, SCK_PAD=0, MOSI_PAD=0, rx_data=0, rx_valid=0, busy=0, tx_ready=1, and clear all counters and shift registers.
REQ-031 Reset asserted mid-frame SHALL abort the frame on the next edge: no rx_valid, no further SCK edges, and CSN_PAD=1 from the following cycle.

Verification
REQ-032 CLK_HALF=6, tx_data=0xA5 with tx_last=1, model peripheral returns 0x3C -> MOSI shows 10100101 on rising edges, rx_data=0x3C with rx_valid at cycle 103, CSN_PAD high at cycle 110, busy low at cycle 116.
REQ-033 Two-byte frame 0x05 (tx_last=0), then 0x07 (tx_last=1) presented in GAP, peripheral returns 0xAA, 0x43 -> CSN_PAD stays low throughout, 16 SCK rises, two rx_valid strobes carrying 0xAA then 0x43.
REQ-034 sys_rst pulsed after the 4th SCK rise of byte 0xFF -> CSN_PAD=1 and SCK_PAD=0 next cycle, no rx_valid; the next frame with 0x81 works normally.
REQ-035 tx_valid held high with 0x11 throughout SHIFT of a tx_last=1 byte -> no acceptance until IDLE, and 0x11 is accepted exactly once after DESEL.
REQ-036 CLK_HALF=1, tx_data=0x5A, peripheral loopback MOSI->MISO -> rx_data=0x5A, SCK period 2 cycles, rx_valid at cycle 18.
REQ-037 Back-to-back single-byte frames with tx_valid held high -> CSN_PAD high for at least CLK_HALF+1 cycles between frames.
